// File: rtl/sec_timer_core_pkg.sv
// Shared definitions for the seconds timer core: default sizing and the
// FSM state encoding used by the timer and anything that decodes its state.
package sec_timer_core_pkg;

    // 13 bits is the narrowest width that holds 99:59 as total seconds
    localparam int DEFAULT_CNT_W   = 13;
    localparam int DEFAULT_MAX_SEC = 5999;

    typedef enum logic [1:0] {
        TMR_IDLE  = 2'd0,
        TMR_RUN   = 2'd1,
        TMR_PAUSE = 2'd2,
        TMR_DONE  = 2'd3
    } tmr_state_t;

endpackage

// File: rtl/sec_timer_core.sv
// Seconds counter for the stopwatch / countdown display path.
// Counts up from 0 or down from a loaded preset on each 1 Hz tick, with
// single-cycle start/stop, clear and load controls. All outputs come from
// registers or from the state register, never directly from inputs.
module sec_timer_core
    import sec_timer_core_pkg::*;
#(
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int MAX_SEC = DEFAULT_MAX_SEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             done_pulse
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SEC);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    tmr_state_t       state, state_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] preset, preset_n;
    logic             dir_q, dir_n;
    logic             hit_terminal;
    logic [CNT_W-1:0] load_clamped;

    // Loads beyond the displayable range saturate at 99:59
    assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    // Next-state and datapath: clear beats load, load (IDLE only) beats start_stop
    always_comb begin
        state_n      = state;
        count_n      = count;
        preset_n     = preset;
        dir_n        = dir_q;
        hit_terminal = 1'b0;

        if (clear) begin
            state_n = TMR_IDLE;
            count_n = dir_q ? '0 : preset;
        end else if (load && (state == TMR_IDLE)) begin
            preset_n = load_clamped;
            count_n  = load_clamped;
            dir_n    = 1'b0;
        end else begin
            case (state)
                TMR_IDLE: begin
                    // A countdown from zero would finish instantly, so it is refused
                    if (start_stop) begin
                        if (dir) begin
                            state_n = TMR_RUN;
                            dir_n   = 1'b1;
                        end else if (count != '0) begin
                            state_n = TMR_RUN;
                            dir_n   = 1'b0;
                        end
                    end
                end
                TMR_RUN: begin
                    if (tick) begin
                        if (dir_q) begin
                            if (count < MAX_CNT) begin
                                count_n = count + ONE_CNT;
                            end else begin
                                hit_terminal = 1'b1;
                            end
                        end else begin
                            // Reaching zero (or already at zero) ends the countdown
                            if (count > ONE_CNT) begin
                                count_n = count - ONE_CNT;
                            end else begin
                                count_n      = '0;
                                hit_terminal = 1'b1;
                            end
                        end
                    end
                    // A terminal tick outranks a coincident pause request
                    if (hit_terminal) begin
                        state_n = TMR_DONE;
                    end else if (start_stop) begin
                        state_n = TMR_PAUSE;
                    end
                end
                TMR_PAUSE: begin
                    if (start_stop) begin
                        state_n = TMR_RUN;
                    end
                end
                TMR_DONE: begin
                    state_n = TMR_DONE;
                end
                default: begin
                    state_n = TMR_IDLE;
                end
            endcase
        end
    end

    // State, count, preset and direction registers plus the DONE-entry pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TMR_IDLE;
            count      <= '0;
            preset     <= '0;
            dir_q      <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            preset     <= preset_n;
            dir_q      <= dir_n;
            done_pulse <= (state_n == TMR_DONE) && (state != TMR_DONE);
        end
    end

    assign running = (state == TMR_RUN);
    assign paused  = (state == TMR_PAUSE);
    assign done    = (state == TMR_DONE);

endmodule

// File: tb/tb_sec_timer_core.sv
// Self-checking bench for sec_timer_core: directed scenarios with literal
// expectations, then random traffic against a behavioural timer model.
module tb_sec_timer_core;

    localparam int CNT_W   = 13;
    localparam int MAX_SEC = 5999;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             start_stop = 1'b0;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic             dir = 1'b1;
    logic [CNT_W-1:0] count;
    logic             running, paused, done, done_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_mode;
    int m_count;
    int m_preset;
    bit m_up;
    bit m_pulse;

    sec_timer_core #(.CNT_W(CNT_W), .MAX_SEC(MAX_SEC)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
        .clear(clear), .load(load), .load_val(load_val), .dir(dir),
        .count(count), .running(running), .paused(paused), .done(done),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge pass, sample 1 time unit later
    task automatic step(input bit tk, input bit ss, input bit cl, input bit ld,
                        input int lv, input bit d);
        tick = tk; start_stop = ss; clear = cl; load = ld;
        load_val = CNT_W'(lv); dir = d;
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_count = 0; m_preset = 0; m_up = 1'b1; m_pulse = 1'b0;
    endtask

    // Timer rules in plain arithmetic: what the display should show after a cycle
    task automatic model_step(input bit tk, input bit ss, input bit cl, input bit ld,
                              input int lv, input bit d);
        int old_mode;
        bit term;
        old_mode = m_mode;
        term = 1'b0;
        if (cl) begin
            m_mode  = M_IDLE;
            m_count = m_up ? 0 : m_preset;
        end else if (ld && m_mode == M_IDLE) begin
            m_preset = (lv > MAX_SEC) ? MAX_SEC : lv;
            m_count  = m_preset;
            m_up     = 1'b0;
        end else if (m_mode == M_IDLE) begin
            if (ss && (d || m_count != 0)) begin
                m_mode = M_RUN;
                m_up   = d;
            end
        end else if (m_mode == M_RUN) begin
            if (tk) begin
                if (m_up) begin
                    if (m_count == MAX_SEC) term = 1'b1;
                    else m_count = m_count + 1;
                end else begin
                    m_count = m_count - 1;
                    if (m_count <= 0) begin
                        m_count = 0;
                        term = 1'b1;
                    end
                end
            end
            if (term) m_mode = M_DONE;
            else if (ss) m_mode = M_PAUSE;
        end else if (m_mode == M_PAUSE) begin
            if (ss) m_mode = M_RUN;
        end
        m_pulse = (m_mode == M_DONE) && (old_mode != M_DONE);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (count !== 13'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        vectors++; if ({running, paused, done, done_pulse} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000", {running, paused, done, done_pulse}); end
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        do_reset();
        step(0, 1, 0, 0, 0, 1);
        vectors++; if (running !== 1'b1) begin miscompares++; $display("[TB] FAIL up_start: running=%b expected 1", running); end
        for (int i = 0; i < 65; i++) begin
            step(1, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0);
        end
        vectors++; if (count !== 13'd65) begin miscompares++; $display("[TB] FAIL up_65: got %0d expected 65", count); end
        vectors++; if (running !== 1'b1) begin miscompares++; $display("[TB] FAIL up_running: got %b expected 1", running); end
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        vectors++; if (count !== 13'd67) begin miscompares++; $display("[TB] FAIL up_67: got %0d expected 67", count); end
        vectors++; if ({running, paused} !== 2'b01) begin miscompares++; $display("[TB] FAIL up_pause: running,paused=%b expected 01", {running, paused}); end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        vectors++; if (count !== 13'd67) begin miscompares++; $display("[TB] FAIL pause_ticks: got %0d expected 67", count); end
    endtask

    task automatic test_countdown();
        do_reset();
        step(0, 0, 0, 1, 3, 0);
        vectors++; if (count !== 13'd3) begin miscompares++; $display("[TB] FAIL cd_load: got %0d expected 3", count); end
        step(0, 1, 0, 0, 3, 0);
        step(1, 0, 0, 0, 3, 0);
        vectors++; if (count !== 13'd2) begin miscompares++; $display("[TB] FAIL cd_2: got %0d expected 2", count); end
        step(1, 0, 0, 0, 3, 0);
        vectors++; if (count !== 13'd1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL cd_1: count=%0d done=%b expected 1/0", count, done); end
        step(1, 0, 0, 0, 3, 0);
        vectors++; if (count !== 13'd0) begin miscompares++; $display("[TB] FAIL cd_0: got %0d expected 0", count); end
        vectors++; if ({done, done_pulse, running} !== 3'b110) begin miscompares++; $display("[TB] FAIL cd_done: done,pulse,running=%b expected 110", {done, done_pulse, running}); end
        step(0, 0, 0, 0, 3, 0);
        vectors++; if ({done, done_pulse} !== 2'b10) begin miscompares++; $display("[TB] FAIL cd_pulse_once: done,pulse=%b expected 10", {done, done_pulse}); end
        step(1, 1, 0, 0, 3, 0);
        step(1, 0, 0, 0, 3, 1);
        vectors++; if (count !== 13'd0 || done !== 1'b1 || done_pulse !== 1'b0) begin miscompares++; $display("[TB] FAIL cd_hold: count=%0d done=%b pulse=%b expected 0/1/0", count, done, done_pulse); end
    endtask

    task automatic test_clamp_terminal();
        do_reset();
        step(0, 0, 0, 1, 8000, 0);
        vectors++; if (count !== 13'd5999) begin miscompares++; $display("[TB] FAIL clamp: got %0d expected 5999", count); end
        step(0, 0, 0, 1, 5998, 0);
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        vectors++; if (count !== 13'd5999 || running !== 1'b1) begin miscompares++; $display("[TB] FAIL term_reach: count=%0d running=%b expected 5999/1", count, running); end
        step(1, 0, 0, 0, 0, 1);
        vectors++; if (count !== 13'd5999 || done !== 1'b1 || done_pulse !== 1'b1) begin miscompares++; $display("[TB] FAIL term_done: count=%0d done=%b pulse=%b expected 5999/1/1", count, done, done_pulse); end
        step(1, 0, 0, 0, 0, 1);
        vectors++; if (count !== 13'd5999) begin miscompares++; $display("[TB] FAIL no_wrap: got %0d expected 5999", count); end
        step(0, 0, 1, 0, 0, 1);
        vectors++; if (count !== 13'd0 || done !== 1'b0 || running !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_up: count=%0d done=%b running=%b expected 0/0/0", count, done, running); end
    endtask

    task automatic test_priority();
        do_reset();
        step(0, 0, 0, 1, 10, 0);
        step(0, 1, 0, 0, 10, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 10, 0);
        vectors++; if (count !== 13'd4) begin miscompares++; $display("[TB] FAIL prio_setup: got %0d expected 4", count); end
        step(0, 1, 1, 1, 7, 0);
        vectors++; if (count !== 13'd10 || {running, paused, done} !== 3'b000) begin miscompares++; $display("[TB] FAIL prio_clear: count=%0d flags=%b expected 10/000", count, {running, paused, done}); end
        step(0, 0, 1, 0, 7, 0);
        vectors++; if (count !== 13'd10) begin miscompares++; $display("[TB] FAIL prio_preset: got %0d expected 10", count); end
    endtask

    task automatic test_ignored_ops();
        do_reset();
        step(0, 0, 0, 1, 10, 0);
        step(0, 1, 0, 0, 10, 0);
        step(1, 0, 0, 0, 10, 0);
        step(0, 0, 0, 1, 50, 0);
        vectors++; if (count !== 13'd9 || running !== 1'b1) begin miscompares++; $display("[TB] FAIL load_in_run: count=%0d running=%b expected 9/1", count, running); end
        step(0, 0, 1, 0, 50, 0);
        vectors++; if (count !== 13'd10) begin miscompares++; $display("[TB] FAIL load_in_run_preset: got %0d expected 10", count); end
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        vectors++; if (running !== 1'b0 || count !== 13'd0) begin miscompares++; $display("[TB] FAIL idle_zero_down: running=%b count=%0d expected 0/0", running, count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 0, 0, 1, 20, 0);
        step(0, 1, 0, 0, 20, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 20, 1);
        vectors++; if (count !== 13'd23) begin miscompares++; $display("[TB] FAIL async_setup: got %0d expected 23", count); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (count !== 13'd0 || {running, paused, done, done_pulse} !== 4'b0000) begin miscompares++; $display("[TB] FAIL async_reset: count=%0d flags=%b expected 0/0000", count, {running, paused, done, done_pulse}); end
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 0, 0, 0, 0, 1);
        vectors++; if (count !== 13'd0 || running !== 1'b0) begin miscompares++; $display("[TB] FAIL async_idle: count=%0d running=%b expected 0/0", count, running); end
    endtask

    task automatic test_random();
        bit tk, ss, cl, ld, d;
        int lv;
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            tk = ($urandom_range(0, 2) == 0);
            ss = ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 9) == 0);
            d  = $urandom_range(0, 1);
            lv = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 8191);
            model_step(tk, ss, cl, ld, lv, d);
            step(tk, ss, cl, ld, lv, d);
            vectors++; if (count !== CNT_W'(m_count)) begin miscompares++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, count, m_count); end
            vectors++; if (running !== (m_mode == M_RUN)) begin miscompares++; $display("[TB] FAIL rnd_running[%0d]: got %b expected %b", i, running, m_mode == M_RUN); end
            vectors++; if (paused !== (m_mode == M_PAUSE)) begin miscompares++; $display("[TB] FAIL rnd_paused[%0d]: got %b expected %b", i, paused, m_mode == M_PAUSE); end
            vectors++; if (done !== (m_mode == M_DONE)) begin miscompares++; $display("[TB] FAIL rnd_done[%0d]: got %b expected %b", i, done, m_mode == M_DONE); end
            vectors++; if (done_pulse !== m_pulse) begin miscompares++; $display("[TB] FAIL rnd_pulse[%0d]: got %b expected %b", i, done_pulse, m_pulse); end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_countdown();
        test_clamp_terminal();
        test_priority();
        test_ignored_ops();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sec_timer_core.md
Name: sec_timer_core

Overview:
Sequential seconds counter that produces the total-seconds value feeding the minute/second digit splitter and the 7-segment path.
- Counts up (stopwatch) or down (countdown from a loaded preset), gated by a 1 Hz tick enable.
- Start/pause, clear and load are single-cycle pulses from the debounce/one-pulse stage.
- Output range is 0..MAX_SEC (99:59 displayed).

Parameters:
CNT_W, 13, width of count/preset/load_val; must hold MAX_SEC
MAX_SEC, 5999, terminal count (99 min 59 s); load values are clamped to this

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tick  input  1  1-cycle pulse at 1 Hz, synchronous to clk
start_stop  input  1  1-cycle pulse; toggles run/pause
clear  input  1  1-cycle pulse; return to IDLE
load  input  1  1-cycle pulse; capture load_val as preset
load_val  input  CNT_W  preset seconds for countdown
dir  input  1  1 = count up, 0 = count down; sampled on start from IDLE
count  output  CNT_W  total seconds, to digit splitter
running  output  1  high in RUN
paused  output  1  high in PAUSE
done  output  1  high in DONE (level)
done_pulse  output  1  1-cycle pulse on DONE entry

Behaviour:
Reset and registers
- Reset is asynchronous and active-high: state=IDLE, count=0, preset=0, dir_q=1, done_pulse=0.
- All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- States (2-bit): IDLE, RUN, PAUSE, DONE.

Input priority per cycle: clear > load > start_stop. Tick is evaluated together with start_stop.

Clear
- Any state -> IDLE.
- count = 0 if dir_q=1; count = preset if dir_q=0.

Load
- Acts only in IDLE; ignored in other states.
- preset = count = min(load_val, MAX_SEC).
- Also sets dir_q=0.

IDLE
- start_stop with dir=1 -> RUN; dir_q=1.
- start_stop with dir=0 and count!=0 -> RUN; dir_q=0.
- start_stop with dir=0 and count==0 is ignored.

RUN
- On tick, dir_q=1:
  - count<MAX_SEC: count+1.
  - count==MAX_SEC: count holds, -> DONE.
- On tick, dir_q=0:
  - count-1.
  - If count was 1: count becomes 0, -> DONE.
- start_stop without tick -> PAUSE.
- start_stop and tick in the same cycle: count updates first; next state is DONE if a terminal condition was hit, else PAUSE.
- The dir input is ignored while running.

PAUSE
- Ticks are ignored; count holds.
- start_stop -> RUN.

DONE
- count holds (MAX_SEC or 0).
- start_stop and tick are ignored.
- Only clear (or rst) exits.

done_pulse
- High exactly the first cycle the state register equals DONE.
- Not re-asserted until DONE is left and re-entered.

Latency: count changes one clk after the tick cycle; running/paused/done follow state with 0 extra cycles.

Arithmetic: count never wraps; it never goes below 0 or above MAX_SEC.

Decomposition:
- Add CNT_W/MAX_SEC defaults and the state encodings (`TMR_IDLE`, `TMR_RUN`, `TMR_PAUSE`, `TMR_DONE`) to the shared global.v include.
- CNT_W must match the counter width macro consumed by the digit splitter.
- One natural sub-module: tick_gen, a clk-to-1 Hz enable divider parameterised by clock frequency. It is instantiated at the top level, not inside this block.
- This block is a single FSM plus datapath.

Test Plan:
- Up count: rst, dir=1, start_stop, 65 ticks -> count=65, running=1; 2 more ticks with start_stop coincident on the last -> count=67, paused=1.
- Countdown: load_val=3, load, dir=0, start_stop, 3 ticks -> count 2,1,0; done=1; done_pulse one cycle on 3rd tick +1; further ticks and start_stop leave count=0, done=1.
- Clamp and terminal: load_val=8000 -> count=5999; clear with dir_q=1 path: rst, dir=1, run from 5998, 2 ticks -> count=5999, DONE, no wrap.
- Priority: clear+load+start_stop in the same cycle while RUN with dir_q=0, preset=10, count=4 -> IDLE, count=10, preset unchanged.
- Ignored ops: load during RUN leaves preset/count unchanged; start_stop in IDLE with dir=0, count=0 stays IDLE; ticks in PAUSE do not change count.
- Async reset: assert rst mid-RUN between clk edges -> count=0, state IDLE, all flags 0 immediately, before the next clk edge.
